// File: rtl/mul_seq_stream.sv
// mul_seq_stream: accepts operand X over valid/ready and streams X*1 .. X*L using a single adder.
// Define MUL_SEQ_STREAM_IDX_EN to expose the current multiplier k on OutIdx.
module mul_seq_stream #(
  parameter int DATA_IN_W  = 5,
  parameter int SEQ_LEN    = 32,
  parameter int LEN_W      = $clog2(SEQ_LEN + 1),
  parameter int DATA_OUT_W = DATA_IN_W + $clog2(SEQ_LEN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_IN_W-1:0]  DataIn,
  input  logic [LEN_W-1:0]      SeqLenIn,
  input  logic                  Flush,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_OUT_W-1:0] DataOut,
  output logic                  OutLast,
  output logic                  Busy
`ifdef MUL_SEQ_STREAM_IDX_EN
  ,
  output logic [LEN_W-1:0]      OutIdx
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SEQ_LEN);

  state_t                r_state, w_state_next;
  logic [DATA_IN_W-1:0]  r_x, w_x_next;
  logic [DATA_OUT_W-1:0] r_acc, w_acc_next;
  logic [LEN_W-1:0]      r_k, w_k_next;
  logic [LEN_W-1:0]      r_len, w_len_next;
  logic [LEN_W-1:0]      w_len_norm;
  logic                  w_last, w_beat, w_load;

  // Zero or out-of-range lengths run the full sequence
  assign w_len_norm = (SeqLenIn == '0 || SeqLenIn > MAX_LEN) ? MAX_LEN : SeqLenIn;

  assign w_last   = (r_k == r_len);
  assign w_beat   = (r_state == S_RUN) && OutReady;
  assign InReady  = !Flush && ((r_state == S_IDLE) || (w_beat && w_last));
  assign w_load   = InValid && InReady;

  assign OutValid = (r_state == S_RUN);
  assign OutLast  = OutValid && w_last;
  assign Busy     = OutValid;
  assign DataOut  = r_acc;

`ifdef MUL_SEQ_STREAM_IDX_EN
  assign OutIdx   = r_k;
`endif

  always_comb begin
    w_state_next = r_state;
    w_x_next     = r_x;
    w_acc_next   = r_acc;
    w_k_next     = r_k;
    w_len_next   = r_len;
    if (Flush) begin
      w_state_next = S_IDLE;
    end else if (w_load) begin
      // A load on the last beat chains the next run with no bubble
      w_state_next = S_RUN;
      w_x_next     = DataIn;
      w_acc_next   = DATA_OUT_W'(DataIn);
      w_k_next     = LEN_W'(1);
      w_len_next   = w_len_norm;
    end else if (w_beat) begin
      if (w_last) begin
        w_state_next = S_IDLE;
      end else begin
        w_acc_next = r_acc + DATA_OUT_W'(r_x);
        w_k_next   = r_k + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_acc   <= '0;
      r_k     <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      r_x     <= w_x_next;
      r_acc   <= w_acc_next;
      r_k     <= w_k_next;
      r_len   <= w_len_next;
    end
  end

endmodule

// File: doc/mul_seq_stream.md
Name: mul_seq_stream

Overview:
- Sequential, single-adder counterpart of the combinational multiple-sequence generator.
- Accepts one operand X over a valid/ready handshake, then streams X*1, X*2, … X*L, one element per accepted output beat.
- L is a per-operand run length in 1..SEQ_LEN.
- Used where a full parallel multiple bank is too costly and consumers (address generators, stride walkers) take one multiple per cycle.

Parameters:
- DATA_IN_W, 5, width of operand X.
- SEQ_LEN, 32, maximum sequence length; must be ≥ 1.
- LEN_W, $clog2(SEQ_LEN+1), width of the run-length input.
- DATA_OUT_W, DATA_IN_W+$clog2(SEQ_LEN), output width; always holds X*SEQ_LEN without overflow.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- InValid  in  1  operand valid.
- InReady  out  1  block can accept an operand.
- DataIn  in  DATA_IN_W  operand X.
- SeqLenIn  in  LEN_W  run length L, sampled with DataIn; 0 or >SEQ_LEN means SEQ_LEN.
- Flush  in  1  synchronous abort of the current sequence.
- OutValid  out  1  DataOut valid.
- OutReady  in  1  consumer accepts the current element.
- DataOut  out  DATA_OUT_W  current element X*k, zero-extended.
- OutLast  out  1  current element is k==L.
- Busy  out  1  sequence in progress (state RUN).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; acc, X register, k, L cleared.
  - OutValid=0, OutLast=0, DataOut=0, Busy=0, InReady=1 (once rst deasserts).
  - Reset mid-sequence discards the sequence silently.
- Registers: Xr (DATA_IN_W), acc (DATA_OUT_W), k and Lr (LEN_W).
- Single adder only: acc_next = acc + zero-extended Xr. No multiplier and no per-element shifter.
- FSM IDLE:
  - InReady=1 unless Flush=1.
  - On InValid&InReady: Xr=DataIn, acc=DataIn, k=1, Lr=normalised SeqLenIn; go to RUN.
  - First element is presented the cycle after acceptance (latency 1).
- FSM RUN:
  - OutValid=1, DataOut=acc, OutLast=(k==Lr), Busy=1.
  - OutValid/DataOut/OutLast are registered-state outputs; they stay stable while OutReady=0.
- Beat accept (OutValid&OutReady), not last: acc+=Xr, k+=1, stay in RUN.
- Beat accept, last:
  - InReady=1 combinationally in the same cycle. This is the only ready-to-ready combinational path.
  - With InValid=1, the new operand loads and RUN continues with no bubble.
  - With InValid=0, go to IDLE.
- L=1: a single element X; OutLast=1 on the first beat.
- X=0: stream of L zeros, full handshake still performed.
- Flush:
  - Highest priority: next state IDLE, OutValid=0 next cycle, pending element dropped.
  - InReady is forced 0 during Flush, so no operand is accepted that cycle.
  - Flush in IDLE is a no-op.
- Stalls: OutReady=0 holds acc and k indefinitely; no elements are lost or duplicated.

Optional Feature:
- Macro MUL_SEQ_STREAM_IDX_EN.
- Defined: adds output port OutIdx (LEN_W), equal to the current multiplier k (1..L), valid with OutValid, reset value 0.
- Undefined: port absent; k remains internal only.
- Sequence behaviour is identical in both builds.

Test Plan:
- Reset, then DataIn=5, SeqLenIn=4, OutReady=1 → DataOut 5,10,15,20 on consecutive cycles; OutLast only with 20; returns to IDLE, InReady=1.
- DataIn=31, SeqLenIn=0 (→32) → last element 992 (fits 10 bits), 32 beats total, OutLast on beat 32.
- DataIn=7, L=3, OutReady toggling 1,0,0,1,0,1 → DataOut holds 14 across stalls; accepted sequence exactly 7,14,21.
- Back-to-back: X=3, L=2, then X=4, L=1 presented on the last-beat cycle → output 3,6,4 with no idle cycle; InReady high on the cycle 6 is accepted.
- Flush asserted while DataOut=10 (X=5, L=8), InValid=1 in the same cycle → next cycle OutValid=0, Busy=0; operand not accepted (InReady=0 during Flush).
- Async rst pulse mid-sequence between clock edges → outputs clear immediately; the next operand starts cleanly from X*1.
